ps2_key_event_ctrl: RTL and testbench

Controller that sequences the PS/2 keyboard receive path. It synchronizes the raw PS/2 clock and data lines into the system clock domain and frames 11-bit PS/2 packets with start, parity and stop checking. It runs the scancode prefix state machine (E0 extended, F0 break) and queues complete key events in a small FIFO with a valid/ready handshake. The downstream style-select and command logic consumes these events instead of raw scancode bytes.

---
 rtl/ps2_key_event_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 tb/tb_ps2_key_event_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl
// PS/2 keyboard receive path: input synchronizer, 11-bit frame receiver with
// start/parity/stop/timeout checking, scancode prefix decoder (E0 / F0) and a
// first-word-fall-through key event FIFO with a valid/ready handshake.
// Optional build macro: PS2_KEY_REPEAT_FILTER_EN drops typematic repeats of
// the most recent make code.
`timescale 1ns/1ps
module ps2_key_event_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_evt_valid,
    input  logic       i_evt_ready,
    output logic [7:0] o_evt_code,
    output logic       o_evt_break,
    output logic       o_evt_ext,
    output logic       o_frame_err,
    output logic       o_overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} frame_state_t;
    typedef enum logic [1:0] {D_BASE, D_EXT, D_BRK, D_EXTBRK} dec_state_t;

    // Odd parity: data ones plus the parity bit must be odd.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // ------------------------------------------------------------------
    // Synchronizer and falling-edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   prev_clk_q;
    logic                   ps2_clk_s;
    logic                   ps2_bit_s;
    logic                   fall_s;

    assign ps2_clk_s = clk_sync_q[SYNC_STAGES-1];
    assign ps2_bit_s = data_sync_q[SYNC_STAGES-1];
    assign fall_s    = prev_clk_q & ~ps2_clk_s;

    // Shift the raw lines through the synchronizer; idle level is 1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            clk_sync_q  <= {SYNC_STAGES{1'b1}};
            data_sync_q <= {SYNC_STAGES{1'b1}};
            prev_clk_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], i_ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], i_ps2_data};
            prev_clk_q  <= ps2_clk_s;
        end
    end

    // ------------------------------------------------------------------
    // Frame receiver
    // ------------------------------------------------------------------
    frame_state_t    frame_q, frame_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_bit_q, par_bit_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_err_q;
    logic            err_s;

    // Frame next-state: bit sampling on falling edges, inter-edge timeout otherwise.
    always_comb begin
        frame_d      = frame_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        tmo_d        = tmo_q;
        byte_valid_d = 1'b0;
        err_s        = 1'b0;
        if (fall_s) begin
            tmo_d = {TW{1'b0}};
            case (frame_q)
                F_IDLE: begin
                    if (!ps2_bit_s) begin
                        frame_d   = F_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                F_DATA: begin
                    shift_d   = {ps2_bit_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        frame_d = F_PARITY;
                    end else begin
                        frame_d = F_DATA;
                    end
                end
                F_PARITY: begin
                    par_bit_d = ps2_bit_s;
                    frame_d   = F_STOP;
                end
                F_STOP: begin
                    if (ps2_bit_s && odd_parity_ok(shift_q, par_bit_q)) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                    frame_d = F_IDLE;
                end
                default: begin
                    frame_d = F_IDLE;
                end
            endcase
        end else if (frame_q != F_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                frame_d = F_IDLE;
                tmo_d   = {TW{1'b0}};
                err_s   = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1'b1);
            end
        end else begin
            tmo_d = {TW{1'b0}};
        end
    end

    // Frame state, shift register, timeout counter and error pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frame_q      <= F_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_bit_q    <= 1'b0;
            tmo_q        <= {TW{1'b0}};
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            frame_q      <= frame_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            tmo_q        <= tmo_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= err_s;
        end
    end

    // ------------------------------------------------------------------
    // Prefix decoder (shift_q still holds the received byte while
    // byte_valid_q is high, since the receiver is back in IDLE)
    // ------------------------------------------------------------------
    dec_state_t dec_q, dec_d;
    logic       evt_s;
    logic       evt_ext_s;
    logic       evt_brk_s;
    logic       is_e0_s;
    logic       is_f0_s;

    assign is_e0_s = (shift_q == 8'hE0);
    assign is_f0_s = (shift_q == 8'hF0);

    // Decode next-state and event generation; any frame error forces BASE.
    always_comb begin
        dec_d     = dec_q;
        evt_s     = 1'b0;
        evt_ext_s = 1'b0;
        evt_brk_s = 1'b0;
        if (err_s) begin
            dec_d = D_BASE;
        end else if (byte_valid_q) begin
            case (dec_q)
                D_BASE: begin
                    if (is_e0_s) begin
                        dec_d = D_EXT;
                    end else if (is_f0_s) begin
                        dec_d = D_BRK;
                    end else begin
                        evt_s = 1'b1;
                    end
                end
                D_EXT: begin
                    if (is_f0_s) begin
                        dec_d = D_EXTBRK;
                    end else if (is_e0_s) begin
                        dec_d = D_EXT;
                    end else begin
                        evt_s     = 1'b1;
                        evt_ext_s = 1'b1;
                        dec_d     = D_BASE;
                    end
                end
                D_BRK: begin
                    if (is_e0_s || is_f0_s) begin
                        dec_d = D_BASE;
                    end else begin
                        evt_s     = 1'b1;
                        evt_brk_s = 1'b1;
                        dec_d     = D_BASE;
                    end
                end
                D_EXTBRK: begin
                    if (is_e0_s || is_f0_s) begin
                        dec_d = D_BASE;
                    end else begin
                        evt_s     = 1'b1;
                        evt_ext_s = 1'b1;
                        evt_brk_s = 1'b1;
                        dec_d     = D_BASE;
                    end
                end
                default: begin
                    dec_d = D_BASE;
                end
            endcase
        end else begin
            dec_d = dec_q;
        end
    end

    // Decoder state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dec_q <= D_BASE;
        end else begin
            dec_q <= dec_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional typematic repeat filter
    // ------------------------------------------------------------------
    logic push_s;

`ifdef PS2_KEY_REPEAT_FILTER_EN
    logic       last_vld_q, last_vld_d;
    logic [8:0] last_key_q, last_key_d;
    logic       last_match_s;

    assign last_match_s = last_vld_q && (last_key_q == {evt_ext_s, shift_q});

    // Drop repeated makes, clear on the matching break, track new makes.
    always_comb begin
        push_s     = evt_s;
        last_vld_d = last_vld_q;
        last_key_d = last_key_q;
        if (evt_s) begin
            if (!evt_brk_s) begin
                if (last_match_s) begin
                    push_s = 1'b0;
                end else begin
                    last_vld_d = 1'b1;
                    last_key_d = {evt_ext_s, shift_q};
                end
            end else if (last_match_s) begin
                last_vld_d = 1'b0;
            end else begin
                last_vld_d = last_vld_q;
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // Last-make register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_vld_q <= 1'b0;
            last_key_q <= 9'h000;
        end else begin
            last_vld_q <= last_vld_d;
            last_key_q <= last_key_d;
        end
    end
`else
    // Every decoded event goes to the FIFO.
    always_comb begin
        push_s = evt_s;
    end
`endif

    // ------------------------------------------------------------------
    // Event FIFO (first-word-fall-through, registered head outputs)
    // ------------------------------------------------------------------
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic [9:0]    head_q, head_d;
    logic          overflow_q;
    logic [9:0]    push_data_s;
    logic          pop_s;
    logic          full_s;
    logic          push_ok_s;
    logic          ovf_s;

    assign push_data_s = {evt_ext_s, evt_brk_s, shift_q};
    assign pop_s       = valid_q & i_evt_ready;
    assign full_s      = (cnt_q == FIFO_FULL);
    assign push_ok_s   = push_s & (~full_s | pop_s);
    assign ovf_s       = push_s & full_s & ~pop_s;

    // Pointer/count update and next head entry; a freshly written entry
    // becomes the head directly when the read pointer lands on it.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_s})
            2'b10:   cnt_d = cnt_q + (AW + 1)'(1'b1);
            2'b01:   cnt_d = cnt_q - (AW + 1)'(1'b1);
            default: cnt_d = cnt_q;
        endcase
        if (cnt_d == {(AW + 1){1'b0}}) begin
            valid_d = 1'b0;
            head_d  = 10'h000;
        end else if (push_ok_s && (rd_ptr_d == wr_ptr_q)) begin
            valid_d = 1'b1;
            head_d  = push_data_s;
        end else begin
            valid_d = 1'b1;
            head_d  = mem_q[rd_ptr_d];
        end
    end

    // FIFO control registers, head outputs and overflow pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            cnt_q      <= {(AW + 1){1'b0}};
            valid_q    <= 1'b0;
            head_q     <= 10'h000;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            overflow_q <= ovf_s;
        end
    end

    // Storage write; contents are qualified by the count, so no reset.
    always_ff @(posedge i_clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data_s;
        end
    end

    assign o_evt_valid = valid_q;
    assign o_evt_ext   = head_q[9];
    assign o_evt_break = head_q[8];
    assign o_evt_code  = head_q[7:0];
    assign o_frame_err = frame_err_q;
    assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed testbench for ps2_key_event_ctrl.
`timescale 1ns/1ps
module tb_ps2_key_event_ctrl;

    localparam int HALF = 10;   // system cycles the PS/2 clock stays low

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_break;
    logic       evt_ext;
    logic       frame_err;
    logic       overflow;

    int vectors    = 0;
    int miscompares = 0;
    int err_cnt    = 0;
    int ovf_cnt    = 0;
    logic [9:0] obs_q [$];

    ps2_key_event_ctrl #(
        .SYNC_STAGES(2),
        .TIMEOUT_CYC(400),
        .FIFO_DEPTH (4)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_data (ps2_data),
        .o_evt_valid(evt_valid),
        .i_evt_ready(evt_ready),
        .o_evt_code (evt_code),
        .o_evt_break(evt_break),
        .o_evt_ext  (evt_ext),
        .o_frame_err(frame_err),
        .o_overflow (overflow)
    );

    always #5 clk = ~clk;

    // Monitor on the falling edge: record accepted events and count pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (evt_valid && evt_ready) obs_q.push_back({evt_ext, evt_break, evt_code});
            if (frame_err) err_cnt++;
            if (overflow) ovf_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_evt(input string tag, input logic [9:0] exp);
        logic [15:0] got;
        if (obs_q.size() == 0) got = 16'hDEAD;
        else got = {6'd0, obs_q.pop_front()};
        check(tag, got, {6'd0, exp});
    endtask

    task automatic ps2_bit(input logic b);
        @(posedge clk); #1;
        ps2_data = b;
        repeat (HALF / 2) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (HALF / 2) @(posedge clk);
    endtask

    // Start bit, 8 data bits LSB first, parity (optionally corrupted).
    task automatic frame_head(input logic [7:0] code, input logic bad_par);
        logic p;
        p = ~(^code) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit(p);
    endtask

    task automatic ps2_frame(input logic [7:0] code, input logic bad_par);
        frame_head(code, bad_par);
        ps2_bit(1'b1);
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic ps2_partial(input logic [7:0] code, input int nbits);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(code[i]);
        ps2_data = 1'b1;
    endtask

    // Stop bit falling edge placed just after a rising edge of clk.
    task automatic stop_fall();
        @(posedge clk); #1;
        ps2_data = 1'b1;
        repeat (HALF / 2) @(posedge clk);
        #1 ps2_clk = 1'b0;
    endtask

    task automatic stop_rise();
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (25) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; evt_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("rst_valid", {15'd0, evt_valid}, 16'd0);
        check("rst_code", {8'd0, evt_code}, 16'd0);
        check("rst_brk", {15'd0, evt_break}, 16'd0);
        check("rst_ext", {15'd0, evt_ext}, 16'd0);
        check("rst_err", {15'd0, frame_err}, 16'd0);
        check("rst_ovf", {15'd0, overflow}, 16'd0);

        // Make 1C with latency check: valid rises 4 clocks after the raw edge
        // (2 sync stages + edge detect + byte_valid + FIFO write).
        frame_head(8'h1C, 1'b0);
        stop_fall();
        repeat (3) @(posedge clk);
        #1 check("lat_early", {15'd0, evt_valid}, 16'd0);
        @(posedge clk);
        #1 check("lat_valid", {15'd0, evt_valid}, 16'd1);
        check("lat_code", {8'd0, evt_code}, 16'h001C);
        stop_rise();
        expect_evt("make_1c", 10'h01C);
        check("make_1c_noerr", 16'(err_cnt), 16'd0);

        // Break and extended break; prefixes produce nothing.
        ps2_frame(8'hF0, 1'b0);
        check("f0_noevt", 16'(obs_q.size()), 16'd0);
        ps2_frame(8'h1C, 1'b0);
        expect_evt("brk_1c", 10'h11C);
        ps2_frame(8'hE0, 1'b0);
        ps2_frame(8'hF0, 1'b0);
        check("e0f0_noevt", 16'(obs_q.size()), 16'd0);
        ps2_frame(8'h74, 1'b0);
        expect_evt("extbrk_74", 10'h374);

        // Parity error, then recovery.
        ps2_frame(8'h1C, 1'b1);
        check("par_err", 16'(err_cnt), 16'd1);
        check("par_noevt", 16'(obs_q.size()), 16'd0);
        ps2_frame(8'h32, 1'b0);
        expect_evt("make_32", 10'h032);

        // Timeout after 4 data bits.
        ps2_partial(8'h55, 4);
        repeat (600) @(posedge clk);
        #1 check("tmo_err", 16'(err_cnt), 16'd2);
        check("tmo_noevt", 16'(obs_q.size()), 16'd0);
        // E0 prefix discarded by an aborted frame.
        ps2_frame(8'hE0, 1'b0);
        ps2_partial(8'h75, 3);
        repeat (600) @(posedge clk);
        #1 check("tmo2_err", 16'(err_cnt), 16'd3);
        ps2_frame(8'h75, 1'b0);
        expect_evt("make_75_noext", 10'h075);

        // Overflow: 5 makes into a 4-deep FIFO with ready low.
        evt_ready = 1'b0;
        for (int c = 8'h15; c <= 8'h19; c++) ps2_frame(8'(c), 1'b0);
        check("ovf_cnt", 16'(ovf_cnt), 16'd1);
        check("ovf_head_valid", {15'd0, evt_valid}, 16'd1);
        check("ovf_head_code", {8'd0, evt_code}, 16'h0015);
        evt_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        expect_evt("drain_15", 10'h015);
        expect_evt("drain_16", 10'h016);
        expect_evt("drain_17", 10'h017);
        expect_evt("drain_18", 10'h018);
        check("drain_empty", 16'(obs_q.size()), 16'd0);
        check("drain_valid0", {15'd0, evt_valid}, 16'd0);

        // Full FIFO with push and pop in the same cycle.
        evt_ready = 1'b0;
        for (int c = 8'h21; c <= 8'h24; c++) ps2_frame(8'(c), 1'b0);
        frame_head(8'h25, 1'b0);
        stop_fall();
        repeat (3) @(posedge clk);
        #1 evt_ready = 1'b1;
        @(posedge clk);
        #1 evt_ready = 1'b0;
        stop_rise();
        check("pushpop_noovf", 16'(ovf_cnt), 16'd1);
        evt_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        expect_evt("pp_21", 10'h021);
        expect_evt("pp_22", 10'h022);
        expect_evt("pp_23", 10'h023);
        expect_evt("pp_24", 10'h024);
        expect_evt("pp_25", 10'h025);

        // Typematic repeat sequence.
        ps2_frame(8'h1C, 1'b0);
        ps2_frame(8'h1C, 1'b0);
        ps2_frame(8'h1C, 1'b0);
        ps2_frame(8'hF0, 1'b0);
        ps2_frame(8'h1C, 1'b0);
        ps2_frame(8'h1C, 1'b0);
`ifdef PS2_KEY_REPEAT_FILTER_EN
        check("rep_count", 16'(obs_q.size()), 16'd3);
        expect_evt("rep_make", 10'h01C);
        expect_evt("rep_brk", 10'h11C);
        expect_evt("rep_remake", 10'h01C);
`else
        check("rep_count", 16'(obs_q.size()), 16'd5);
        expect_evt("rep_make1", 10'h01C);
        expect_evt("rep_make2", 10'h01C);
        expect_evt("rep_make3", 10'h01C);
        expect_evt("rep_brk", 10'h11C);
        expect_evt("rep_make4", 10'h01C);
`endif
        check("final_err", 16'(err_cnt), 16'd3);
        check("final_ovf", 16'(ovf_cnt), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
